// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO responder (PHY side): oversamples MDC/MDIO in the aclk domain, decodes
// read/write frames addressed to PHY_ADDR and serves BMCR, BMSR and the two PHY ID registers.
module mdio_phy_responder #(
  parameter logic [4:0]  PHY_ADDR    = 5'd1,
  parameter logic [15:0] PHY_ID1     = 16'h0022,
  parameter logic [15:0] PHY_ID2     = 16'h1560,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic mdc,
  input  logic md_i,
  output logic md_o,
  output logic md_t,
  input  logic link_up,
  output logic ctrl_loopback,
  output logic ctrl_speed100,
  output logic ctrl_duplex,
  output logic soft_reset
);

  typedef enum logic [2:0] {
    S_IDLE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA
  } state_t;

  logic [SYNC_STAGES-1:0] mdc_sync_q, md_sync_q;
  logic        mdc_q;
  logic        mdc_s, md_s, rise_s, fall_s;
  state_t      state_q, state_d;
  logic [5:0]  pre_cnt_q, pre_cnt_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic        op_bit_q, op_bit_d;
  logic        is_read_q, is_read_d;
  logic        match_q, match_d;
  logic [4:0]  addr_q, addr_d;
  logic [4:0]  regad_q, regad_d;
  logic [15:0] shreg_q, shreg_d;
  logic        md_o_q, md_o_d, md_t_q, md_t_d;
  logic        lb_q, lb_d, spd_q, spd_d, aneg_q, aneg_d, dup_q, dup_d;
  logic        link_lat_q, link_lat_d;
  logic        soft_reset_q, soft_reset_d;
  logic        rd1_done_s;
  logic [15:0] bmcr_s, bmsr_s;

  function automatic logic [15:0] reg_read(input logic [4:0]  ra,
                                           input logic [15:0] bmcr,
                                           input logic [15:0] bmsr);
    logic [15:0] v;
    case (ra)
      5'd0:    v = bmcr;
      5'd1:    v = bmsr;
      5'd2:    v = PHY_ID1;
      5'd3:    v = PHY_ID2;
      default: v = 16'h0000;
    endcase
    return v;
  endfunction

  assign mdc_s  = mdc_sync_q[SYNC_STAGES-1];
  assign md_s   = md_sync_q[SYNC_STAGES-1];
  assign rise_s = mdc_s & ~mdc_q;
  assign fall_s = ~mdc_s & mdc_q;
  assign bmcr_s = {1'b0, lb_q, spd_q, aneg_q, 3'b000, dup_q, 8'h00};
  assign bmsr_s = 16'h7809 | {10'd0, link_up, 2'b00, link_lat_q, 2'b00};

  always_comb begin
    state_d      = state_q;
    pre_cnt_d    = pre_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    op_bit_d     = op_bit_q;
    is_read_d    = is_read_q;
    match_d      = match_q;
    addr_d       = addr_q;
    regad_d      = regad_q;
    shreg_d      = shreg_q;
    md_o_d       = md_o_q;
    md_t_d       = md_t_q;
    lb_d         = lb_q;
    spd_d        = spd_q;
    aneg_d       = aneg_q;
    dup_d        = dup_q;
    soft_reset_d = 1'b0;
    rd1_done_s   = 1'b0;

    if (rise_s) begin
      case (state_q)
        S_IDLE: begin
          if (md_s) begin
            if (pre_cnt_q != 6'd32) begin
              pre_cnt_d = pre_cnt_q + 6'd1;
            end else begin
              pre_cnt_d = pre_cnt_q;
            end
          end else if (pre_cnt_q == 6'd32) begin
            state_d   = S_ST;
            pre_cnt_d = 6'd0;
          end else begin
            pre_cnt_d = 6'd0;
          end
        end
        S_ST: begin
          bit_cnt_d = 4'd0;
          if (md_s) begin
            state_d = S_OP;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_OP: begin
          if (bit_cnt_q == 4'd0) begin
            op_bit_d  = md_s;
            bit_cnt_d = 4'd1;
          end else begin
            bit_cnt_d = 4'd0;
            is_read_d = op_bit_q;
            if (op_bit_q != md_s) begin
              state_d = S_PHYAD;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_PHYAD: begin
          addr_d = {addr_q[3:0], md_s};
          if (bit_cnt_q == 4'd4) begin
            match_d   = ({addr_q[3:0], md_s} == PHY_ADDR);
            bit_cnt_d = 4'd0;
            state_d   = S_REGAD;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        S_REGAD: begin
          addr_d = {addr_q[3:0], md_s};
          if (bit_cnt_q == 4'd4) begin
            // Read data is snapshotted here, so a link change mid-frame is not seen.
            regad_d   = {addr_q[3:0], md_s};
            shreg_d   = reg_read({addr_q[3:0], md_s}, bmcr_s, bmsr_s);
            bit_cnt_d = 4'd0;
            state_d   = S_TA;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        S_TA: begin
          if (bit_cnt_q == 4'd0) begin
            bit_cnt_d = 4'd1;
          end else begin
            bit_cnt_d = 4'd0;
            state_d   = S_DATA;
          end
        end
        S_DATA: begin
          shreg_d = {shreg_q[14:0], md_s};
          if (bit_cnt_q == 4'd15) begin
            bit_cnt_d = 4'd0;
            pre_cnt_d = 6'd0;
            state_d   = S_IDLE;
            if (match_q && !is_read_q && (regad_q == 5'd0)) begin
              // Shift register still lags one bit: shreg_q[k] holds data bit k+1.
              if (shreg_q[14]) begin
                soft_reset_d = 1'b1;
                lb_d         = 1'b0;
                spd_d        = 1'b1;
                aneg_d       = 1'b1;
                dup_d        = 1'b1;
              end else begin
                lb_d   = shreg_q[13];
                spd_d  = shreg_q[12];
                aneg_d = shreg_q[11];
                dup_d  = shreg_q[7];
              end
            end else begin
              lb_d = lb_q;
            end
            if (match_q && is_read_q && (regad_q == 5'd1)) begin
              rd1_done_s = 1'b1;
            end else begin
              rd1_done_s = 1'b0;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        default: begin
          state_d   = S_IDLE;
          pre_cnt_d = 6'd0;
          bit_cnt_d = 4'd0;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    if (fall_s) begin
      if (match_q && is_read_q && (state_q == S_TA) && (bit_cnt_q == 4'd1)) begin
        md_t_d = 1'b0;
        md_o_d = 1'b0;
      end else if (match_q && is_read_q && (state_q == S_DATA)) begin
        md_t_d = 1'b0;
        md_o_d = shreg_q[15];
      end else begin
        md_t_d = 1'b1;
        md_o_d = 1'b0;
      end
    end else begin
      md_t_d = md_t_q;
    end

    // Latch-low link status: any low sample wins over a concurrent read completion.
    if (!link_up) begin
      link_lat_d = 1'b0;
    end else if (rd1_done_s) begin
      link_lat_d = link_up;
    end else begin
      link_lat_d = link_lat_q;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      mdc_sync_q   <= '0;
      md_sync_q    <= '0;
      mdc_q        <= 1'b0;
      state_q      <= S_IDLE;
      pre_cnt_q    <= 6'd0;
      bit_cnt_q    <= 4'd0;
      op_bit_q     <= 1'b0;
      is_read_q    <= 1'b0;
      match_q      <= 1'b0;
      addr_q       <= 5'd0;
      regad_q      <= 5'd0;
      shreg_q      <= 16'h0000;
      md_o_q       <= 1'b0;
      md_t_q       <= 1'b1;
      lb_q         <= 1'b0;
      spd_q        <= 1'b1;
      aneg_q       <= 1'b1;
      dup_q        <= 1'b1;
      link_lat_q   <= 1'b0;
      soft_reset_q <= 1'b0;
    end else begin
      mdc_sync_q   <= {mdc_sync_q[SYNC_STAGES-2:0], mdc};
      md_sync_q    <= {md_sync_q[SYNC_STAGES-2:0], md_i};
      mdc_q        <= mdc_s;
      state_q      <= state_d;
      pre_cnt_q    <= pre_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      op_bit_q     <= op_bit_d;
      is_read_q    <= is_read_d;
      match_q      <= match_d;
      addr_q       <= addr_d;
      regad_q      <= regad_d;
      shreg_q      <= shreg_d;
      md_o_q       <= md_o_d;
      md_t_q       <= md_t_d;
      lb_q         <= lb_d;
      spd_q        <= spd_d;
      aneg_q       <= aneg_d;
      dup_q        <= dup_d;
      link_lat_q   <= link_lat_d;
      soft_reset_q <= soft_reset_d;
    end
  end

  assign md_o          = md_o_q;
  assign md_t          = md_t_q;
  assign ctrl_loopback = lb_q;
  assign ctrl_speed100 = spd_q;
  assign ctrl_duplex   = dup_q;
  assign soft_reset    = soft_reset_q;

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Scoreboard bench for mdio_phy_responder: an MDIO master drives frames, a register-map model
// queues expected read words, and an MDC-rise monitor captures what the PHY drives back.
module tb_mdio_phy_responder;
  localparam logic [4:0] PHY = 5'd1;
  localparam logic [1:0] OP_RD = 2'b10;
  localparam logic [1:0] OP_WR = 2'b01;

  logic aclk = 1'b0, aresetn = 1'b0, mdc = 1'b0, mst_md = 1'b1, link_up = 1'b1;
  logic md_i, md_o, md_t, ctrl_loopback, ctrl_speed100, ctrl_duplex, soft_reset;

  // Open-drain bus with pull-up: the PHY wins while it drives.
  assign md_i = md_t ? mst_md : md_o;
  always #5 aclk = ~aclk;

  mdio_phy_responder #(.PHY_ADDR(PHY), .PHY_ID1(16'h0022), .PHY_ID2(16'h1560), .SYNC_STAGES(2)) dut (
    .aclk(aclk), .aresetn(aresetn), .mdc(mdc), .md_i(md_i), .md_o(md_o), .md_t(md_t),
    .link_up(link_up), .ctrl_loopback(ctrl_loopback), .ctrl_speed100(ctrl_speed100),
    .ctrl_duplex(ctrl_duplex), .soft_reset(soft_reset)
  );

  int n_checks = 0, n_pass = 0;
  logic [15:0] exp_q[$];
  bit abort_ok = 1'b0;
  logic [15:0] m_bmcr = 16'h3100;
  bit m_lat = 1'b0;
  int exp_pulses = 0, pulses = 0, sr_width = 0, width_bad = 0, drive_cycles = 0;
  int nbits = 0;
  logic [16:0] cap;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
  endtask

  function automatic logic [15:0] model_read(input logic [4:0] ra);
    case (ra)
      5'd0: return m_bmcr;
      5'd1: return 16'h7809 + (link_up ? 16'd32 : 16'd0) + (m_lat ? 16'd4 : 16'd0);
      5'd2: return 16'h0022;
      5'd3: return 16'h1560;
      default: return 16'h0000;
    endcase
  endfunction

  // Monitor: master-side sampling of the PHY on every MDC rise.
  always @(posedge mdc) begin
    logic [15:0] e;
    if (md_t == 1'b0) begin
      cap = {cap[15:0], md_o};
      nbits++;
      if (nbits == 17) begin
        nbits = 0;
        if (!abort_ok) begin
          chk("drive_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("rd_ta_bit", cap[16], 1'b0);
            chk("rd_data", cap[15:0], e);
          end
        end
      end
    end else if (nbits != 0) begin
      if (!abort_ok) chk("rd_window_len", nbits, 17);
      nbits = 0;
    end
  end

  // soft_reset pulse counter / width checker, plus raw drive-cycle counter.
  always @(negedge aclk) begin
    if (!md_t) drive_cycles++;
    if (soft_reset) sr_width++;
    else if (sr_width != 0) begin
      pulses++;
      if (sr_width != 1) width_bad++;
      sr_width = 0;
    end
  end

  task automatic mdc_bit(input logic b);
    @(negedge aclk); mst_md = b;
    repeat (4) @(negedge aclk); mdc = 1'b1;
    repeat (8) @(negedge aclk); mdc = 1'b0;
    repeat (3) @(negedge aclk);
  endtask

  task automatic do_reset();
    chk("driving_before_abort", md_t, 1'b0);
    @(negedge aclk); aresetn = 1'b0;
    @(negedge aclk); chk("md_t_after_reset", md_t, 1'b1);
    aresetn = 1'b1;
    m_bmcr = 16'h3100;
    m_lat = 1'b0;
  endtask

  task automatic frame(input int pre, input logic [1:0] op, input logic [4:0] pa,
                       input logic [4:0] ra, input logic [15:0] wd, input int abort_at);
    bit q[$];
    q.push_back(1'b0);
    repeat (pre) q.push_back(1'b1);
    q.push_back(1'b0); q.push_back(1'b1);
    q.push_back(op[1]); q.push_back(op[0]);
    for (int i = 4; i >= 0; i--) q.push_back(pa[i]);
    for (int i = 4; i >= 0; i--) q.push_back(ra[i]);
    if (op == OP_WR) begin
      q.push_back(1'b1); q.push_back(1'b0);
      for (int i = 15; i >= 0; i--) q.push_back(wd[i]);
    end else begin
      repeat (18) q.push_back(1'b1);
    end
    for (int i = 0; i < q.size(); i++) begin
      if (i == abort_at) begin
        do_reset();
        return;
      end
      mdc_bit(q[i]);
    end
  endtask

  task automatic transact(input int pre, input logic [1:0] op, input logic [4:0] pa,
                          input logic [4:0] ra, input logic [15:0] wd);
    bit valid;
    valid = (pre >= 32) && (pa == PHY) && ((op == OP_RD) || (op == OP_WR));
    if (valid && op == OP_RD) exp_q.push_back(model_read(ra));
    frame(pre, op, pa, ra, wd, -1);
    if (valid && op == OP_WR && ra == 5'd0) begin
      if (wd[15]) begin
        m_bmcr = 16'h3100;
        exp_pulses++;
      end else begin
        m_bmcr = wd & 16'h7100;
      end
    end
    if (valid && op == OP_RD && ra == 5'd1) m_lat = link_up;
    repeat (4) @(negedge aclk);
    chk("ctrl_loopback", ctrl_loopback, m_bmcr[14]);
    chk("ctrl_speed100", ctrl_speed100, m_bmcr[13]);
    chk("ctrl_duplex", ctrl_duplex, m_bmcr[8]);
    chk("soft_reset_pulses", pulses, exp_pulses);
  endtask

  task automatic set_link(input logic v);
    @(negedge aclk); link_up = v;
    if (!v) m_lat = 1'b0;
    repeat (2) @(negedge aclk);
  endtask

  initial begin
    int d0;
    // Reset state
    repeat (2) @(negedge aclk);
    chk("rst_md_t", md_t, 1'b1);
    chk("rst_speed100", ctrl_speed100, 1'b1);
    chk("rst_duplex", ctrl_duplex, 1'b1);
    chk("rst_loopback", ctrl_loopback, 1'b0);
    chk("rst_soft_reset", soft_reset, 1'b0);
    aresetn = 1'b1;
    repeat (3) @(negedge aclk);
    transact(32, OP_RD, PHY, 5'd0, 16'h0);
    transact(32, OP_RD, PHY, 5'd2, 16'h0);
    transact(33, OP_RD, PHY, 5'd3, 16'h0);
    // BMCR writes and soft reset
    transact(32, OP_WR, PHY, 5'd0, 16'h4000);
    transact(32, OP_RD, PHY, 5'd0, 16'h0);
    transact(32, OP_WR, PHY, 5'd0, 16'h8000);
    transact(32, OP_RD, PHY, 5'd0, 16'h0);
    // Latch-low link status
    set_link(1'b0); set_link(1'b1);
    transact(32, OP_RD, PHY, 5'd1, 16'h0);
    transact(32, OP_RD, PHY, 5'd1, 16'h0);
    set_link(1'b0);
    transact(32, OP_RD, PHY, 5'd1, 16'h0);
    set_link(1'b1);
    transact(32, OP_RD, PHY, 5'd1, 16'h0);
    // Frames that must be ignored
    d0 = drive_cycles;
    transact(32, OP_RD, 5'd2, 5'd2, 16'h0);
    transact(32, OP_WR, 5'd2, 5'd0, 16'h4000);
    transact(31, OP_RD, PHY, 5'd2, 16'h0);
    transact(31, OP_WR, PHY, 5'd0, 16'h4000);
    transact(32, 2'b11, PHY, 5'd0, 16'h0);
    chk("no_drive_ignored_frames", drive_cycles - d0, 0);
    transact(32, OP_RD, PHY, 5'd0, 16'h0);
    // Reset in the middle of read data, then a clean read
    abort_ok = 1'b1;
    frame(32, OP_RD, PHY, 5'd2, 16'h0, 54);
    mdc_bit(1'b0);
    abort_ok = 1'b0;
    transact(32, OP_RD, PHY, 5'd2, 16'h0);
    transact(32, OP_RD, PHY, 5'd0, 16'h0);
    // Randomised traffic against the register model
    for (int n = 0; n < 28; n++) begin
      int pre, r;
      logic [1:0] op;
      logic [4:0] pa, ra;
      logic [15:0] wd;
      pre = ($urandom_range(0, 7) == 0) ? 31 : 32 + $urandom_range(0, 2);
      r = $urandom_range(0, 9);
      op = (r == 0) ? (($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11) : ((r <= 5) ? OP_RD : OP_WR);
      pa = ($urandom_range(0, 9) < 7) ? PHY : 5'($urandom_range(0, 31));
      ra = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 4));
      wd = 16'($urandom_range(0, 65535));
      wd[15] = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) set_link(~link_up);
      transact(pre, op, pa, ra, wd);
    end
    mdc_bit(1'b1);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("soft_reset_width", width_bad, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
